monitor_sched: RTL and testbench

MONITOR_SCHED -- requirements
Module: monitor_sched

---
 rtl/monitor_sched.sv | 139 +++++++++++++
 tb/tb_monitor_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_sched.sv
// monitor_sched: round-robin scheduler sharing one protocol monitor among 4 cores.
// Optional grant timeout is built when MONITOR_SCHED_TIMEOUT_EN is defined.
module monitor_sched #(
    parameter int TIMEOUT_W  = 16,
    parameter int SWITCH_GAP = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [3:0]           pkt_done,
`ifdef MONITOR_SCHED_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic                 timeout_err,
`endif
    output logic [1:0]           sel,
    output logic [3:0]           grant,
    output logic                 monitor_valid,
    output logic [3:0]           stall
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(SWITCH_GAP - 1);

    state_t     r_state;
    state_t     w_state_nx;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nx;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nx;
    logic [3:0] r_gap_cnt;
    logic [3:0] w_gap_cnt_nx;
    logic [1:0] w_win;
    logic       w_any;
    logic       w_done;
    logic       w_abandon;
    logic       w_to_hit;

    if (TIMEOUT_W < 1 || SWITCH_GAP < 1 || SWITCH_GAP > 15) begin : g_bad_param
    end

    // Search ptr+1, ptr+2, ptr+3, ptr; first requester wins.
    always_comb begin
        w_win = r_ptr;
        w_any = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_any && req[r_ptr + 2'(k)]) begin
                w_win = r_ptr + 2'(k);
                w_any = 1'b1;
            end
        end
    end

    assign w_done    = pkt_done[r_sel];
    assign w_abandon = !req[r_sel];

`ifdef MONITOR_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic [TIMEOUT_W-1:0] w_to_cnt_nx;
    logic                 r_to_err;
    logic                 w_to_err_nx;

    assign w_to_hit = (timeout_limit != '0) && (r_to_cnt == timeout_limit);

    always_comb begin
        w_to_cnt_nx = r_to_cnt;
        if (r_state == IDLE && w_any)
            w_to_cnt_nx = TIMEOUT_W'(1);
        else if (r_state == GRANT)
            w_to_cnt_nx = r_to_cnt + TIMEOUT_W'(1);
    end

    // A coincident pkt_done ends the grant normally, without an error.
    assign w_to_err_nx = (r_state == GRANT) && w_to_hit && !w_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nx;
            r_to_err <= w_to_err_nx;
        end
    end

    assign timeout_err = r_to_err;
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_sel_nx     = r_sel;
        w_ptr_nx     = r_ptr;
        w_gap_cnt_nx = r_gap_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx = GRANT;
                    w_sel_nx   = w_win;
                    w_ptr_nx   = w_win;
                end
            end
            GRANT: begin
                if (w_done || w_abandon || w_to_hit) begin
                    w_state_nx   = GAP;
                    w_gap_cnt_nx = '0;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST)
                    w_state_nx = IDLE;
                else
                    w_gap_cnt_nx = r_gap_cnt + 4'd1;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sel     <= 2'd0;
            r_ptr     <= 2'd3;
            r_gap_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nx;
            r_sel     <= w_sel_nx;
            r_ptr     <= w_ptr_nx;
            r_gap_cnt <= w_gap_cnt_nx;
        end
    end

    assign sel           = r_sel;
    assign monitor_valid = (r_state == GRANT);
    assign grant         = monitor_valid ? (4'b0001 << r_sel) : 4'b0000;
    assign stall         = req & ~grant;

endmodule

// File: tb/tb_monitor_sched.sv
// tb_monitor_sched: directed tests for the shared-monitor scheduler.
// Timeout scenarios run only when MONITOR_SCHED_TIMEOUT_EN is defined.
module tb_monitor_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] pkt_done = 4'b0000;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       monitor_valid;
    logic [3:0] stall;
`ifdef MONITOR_SCHED_TIMEOUT_EN
    logic [15:0] timeout_limit = 16'd0;
    logic        timeout_err;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    monitor_sched #(.TIMEOUT_W(16), .SWITCH_GAP(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .pkt_done      (pkt_done),
`ifdef MONITOR_SCHED_TIMEOUT_EN
        .timeout_limit (timeout_limit),
        .timeout_err   (timeout_err),
`endif
        .sel           (sel),
        .grant         (grant),
        .monitor_valid (monitor_valid),
        .stall         (stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; the next edge is the first arbitration.
    task automatic do_reset;
        reset = 1'b1;
        req = 4'b0000;
        pkt_done = 4'b0000;
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({sel, grant, monitor_valid, stall} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state got sel=%0d grant=%b mv=%b stall=%b want 0",
                     sel, grant, monitor_valid, stall);
        end
        req = 4'b1111;
        tick;
        total++;
        if ({grant, monitor_valid, stall} !== {4'b0000, 1'b0, 4'b1111}) begin
            bad++;
            $display("FAIL reset_hold got grant=%b mv=%b stall=%b want 0000 0 1111",
                     grant, monitor_valid, stall);
        end
`ifdef MONITOR_SCHED_TIMEOUT_EN
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_to_err got %b want 0", timeout_err);
        end
`endif
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        logic [3:0] oh;
        do_reset();
        req = 4'b1111;
        tick;
        for (int g = 0; g < 5; g++) begin
            e = 2'(g);
            oh = 4'b0001 << e;
            for (int c = 1; c <= 5; c++) begin
                total++;
                if ({sel, grant, monitor_valid} !== {e, oh, 1'b1}) begin
                    bad++;
                    $display("FAIL rr_grant g=%0d c=%0d got sel=%0d grant=%b mv=%b want sel=%0d grant=%b mv=1",
                             g, c, sel, grant, monitor_valid, e, oh);
                end
                if (c == 5) pkt_done = oh;
                tick;
                pkt_done = 4'b0000;
            end
            for (int c = 0; c < 3; c++) begin
                total++;
                if ({sel, grant, monitor_valid} !== {e, 4'b0000, 1'b0}) begin
                    bad++;
                    $display("FAIL rr_gap g=%0d c=%0d got sel=%0d grant=%b mv=%b want sel=%0d grant=0000 mv=0",
                             g, c, sel, grant, monitor_valid, e);
                end
                tick;
            end
        end
    endtask

    task automatic test_ptr;
        do_reset();
        req = 4'b0010;
        tick;
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL ptr_first got grant=%b want 0010", grant);
        end
        req = 4'b0101;
        pkt_done = 4'b0010;
        tick;
        pkt_done = 4'b0000;
        total++;
        if (monitor_valid !== 1'b0) begin
            bad++;
            $display("FAIL ptr_gap got mv=%b want 0", monitor_valid);
        end
        repeat (3) tick;
        total++;
        if ({grant, stall} !== {4'b0100, 4'b0001}) begin
            bad++;
            $display("FAIL ptr_core2 got grant=%b stall=%b want 0100 0001", grant, stall);
        end
        pkt_done = 4'b0100;
        tick;
        pkt_done = 4'b0000;
        repeat (3) tick;
        total++;
        if ({sel, grant} !== {2'd0, 4'b0001}) begin
            bad++;
            $display("FAIL ptr_core0 got sel=%0d grant=%b want 0 0001", sel, grant);
        end
    endtask

    task automatic test_ignore_other_done;
        do_reset();
        req = 4'b0010;
        tick;
        req = 4'b0011;
        pkt_done = 4'b0001;
        tick;
        pkt_done = 4'b0000;
        total++;
        if ({grant, monitor_valid} !== {4'b0010, 1'b1}) begin
            bad++;
            $display("FAIL ignore_done got grant=%b mv=%b want 0010 1", grant, monitor_valid);
        end
        req = 4'b0001;
        #1;
        total++;
        if ({grant, stall} !== {4'b0010, 4'b0001}) begin
            bad++;
            $display("FAIL abandon_same got grant=%b stall=%b want 0010 0001", grant, stall);
        end
        tick;
        total++;
        if ({grant, monitor_valid, stall} !== {4'b0000, 1'b0, 4'b0001}) begin
            bad++;
            $display("FAIL abandon_gap got grant=%b mv=%b stall=%b want 0000 0 0001",
                     grant, monitor_valid, stall);
        end
    endtask

    task automatic test_single_regrant;
        do_reset();
        req = 4'b0001;
        tick;
        pkt_done = 4'b0001;
        tick;
        pkt_done = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (monitor_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_gap c=%0d got mv=%b want 0", c, monitor_valid);
            end
            tick;
        end
        total++;
        if ({grant, monitor_valid} !== {4'b0001, 1'b1}) begin
            bad++;
            $display("FAIL single_regrant got grant=%b mv=%b want 0001 1", grant, monitor_valid);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 4'b0100;
        tick;
        total++;
        if ({sel, grant} !== {2'd2, 4'b0100}) begin
            bad++;
            $display("FAIL ares_pre got sel=%0d grant=%b want 2 0100", sel, grant);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({sel, grant, monitor_valid} !== {2'd0, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL ares_drop got sel=%0d grant=%b mv=%b want 0 0000 0",
                     sel, grant, monitor_valid);
        end
        req = 4'b1000;
        #2;
        reset = 1'b0;
        tick;
        total++;
        if ({sel, grant} !== {2'd3, 4'b1000}) begin
            bad++;
            $display("FAIL ares_after got sel=%0d grant=%b want 3 1000", sel, grant);
        end
    endtask

    task automatic test_long_packet;
        int n;
        int errs;
        n = 0;
        errs = 0;
        do_reset();
`ifdef MONITOR_SCHED_TIMEOUT_EN
        timeout_limit = 16'd0;
`endif
        req = 4'b0001;
        tick;
        repeat (1000) begin
            if (monitor_valid) n++;
`ifdef MONITOR_SCHED_TIMEOUT_EN
            if (timeout_err) errs++;
`endif
            tick;
        end
        total++;
        if (n !== 1000) begin
            bad++;
            $display("FAIL long_valid got %0d cycles want 1000", n);
        end
        pkt_done = 4'b0001;
        tick;
        pkt_done = 4'b0000;
        total++;
        if (monitor_valid !== 1'b0) begin
            bad++;
            $display("FAIL long_end got mv=%b want 0", monitor_valid);
        end
`ifdef MONITOR_SCHED_TIMEOUT_EN
        if (timeout_err) errs++;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL long_to_err got %0d pulses want 0", errs);
        end
`endif
    endtask

`ifdef MONITOR_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        n = 0;
        do_reset();
        timeout_limit = 16'd8;
        req = 4'b0001;
        tick;
        while (monitor_valid && n < 20) begin
            n++;
            tick;
        end
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL to_valid got %0d cycles want 8", n);
        end
        total++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL to_pulse got %b want 1", timeout_err);
        end
        tick;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse_end got %b want 0", timeout_err);
        end
        tick;
        tick;
        for (int c = 1; c <= 8; c++) begin
            total++;
            if (monitor_valid !== 1'b1) begin
                bad++;
                $display("FAIL to_regrant c=%0d got mv=%b want 1", c, monitor_valid);
            end
            if (c == 8) pkt_done = 4'b0001;
            tick;
            pkt_done = 4'b0000;
        end
        total++;
        if ({monitor_valid, timeout_err} !== 2'b00) begin
            bad++;
            $display("FAIL to_done_prio got mv=%b err=%b want 0 0", monitor_valid, timeout_err);
        end
        timeout_limit = 16'd0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_ptr();
        test_ignore_other_done();
        test_single_regrant();
        test_async_reset();
        test_long_packet();
`ifdef MONITOR_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
